// File: rtl/mem_responder_pkg.sv
// Shared memory-interface types: physical line pointers and cacheline payloads.
// Offset bits below line_off_bits select a byte within a line and are ignored here.
package mem_responder_pkg;

    localparam int PPTR_W          = 20;
    localparam int CACHELINE_W     = 128;
    localparam int LINE_OFF_BITS   = 4;
    localparam int CACHELINE_BYTES = 16;

    typedef logic [PPTR_W-1:0]      pptr_t;
    typedef logic [CACHELINE_W-1:0] cacheline_t;

    function automatic pptr_t line_align(pptr_t a);
        return {a[PPTR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// Pending-read FIFO: each entry counts down from LATENCY and pops at the head on reaching zero.
// A CAM over all queued line addresses lets the caller drop repeated requests.
module mem_resp_queue
    import mem_responder_pkg::*;
#(
    parameter int QDEPTH  = 8,
    parameter int LATENCY = 5
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  enq,
    input  pptr_t enq_addr,
    input  pptr_t match_addr,
    output logic  match,
    output logic  pop,
    output pptr_t pop_addr
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NW = $clog2(QDEPTH + 1);

    pptr_t             addr_q [QDEPTH];
    logic [CW-1:0]     cnt_q  [QDEPTH];
    logic [QDEPTH-1:0] vld_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [NW-1:0]     count_q;
    logic              full;

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == NW'(QDEPTH));
    assign pop      = vld_q[head_q] && (cnt_q[head_q] == CW'(1));
    assign pop_addr = addr_q[head_q];

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (vld_q[i] && addr_q[i] == match_addr) begin
                match = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (vld_q[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= nxt(head_q);
            end
            // Push after pop so a full queue can recycle the head slot.
            if (enq) begin
                addr_q[tail_q] <= enq_addr;
                cnt_q[tail_q]  <= CW'(LATENCY);
                vld_q[tail_q]  <= 1'b1;
                tail_q         <= nxt(tail_q);
            end
            count_q <= count_q + NW'(enq) - NW'(pop);
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(enq && full && !pop)
    ) else $error("mem_resp_queue: enqueue while full");

endmodule

// File: rtl/mem_responder.sv
// Line-granular main memory model: writes land immediately, reads answer after LATENCY.
// Response data is fetched at pop time, with same-edge write forwarding.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY   = 5,
    parameter int QDEPTH    = 8,
    parameter int MEM_LINES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_ren,
    input  pptr_t       mem_req_raddr,
    input  logic        mem_req_wen,
    input  pptr_t       mem_req_waddr,
    input  cacheline_t  mem_req_wcacheline,
    output logic        mem_rec_en,
    output pptr_t       mem_rec_addr,
    output cacheline_t  mem_rec_cacheline,
    output logic [31:0] rd_accepted,
    output logic [31:0] wr_accepted
);

    localparam int IW = $clog2(MEM_LINES);

    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_responder: LATENCY must be >= 1");
    end
    if (QDEPTH < LATENCY) begin : g_bad_qdepth
        $error("mem_responder: QDEPTH must be >= LATENCY");
    end
    if ((1 << IW) != MEM_LINES) begin : g_bad_lines
        $error("mem_responder: MEM_LINES must be a power of two");
    end

    cacheline_t    mem [MEM_LINES];
    logic [IW-1:0] widx;
    logic [IW-1:0] pidx;
    pptr_t         rline;
    pptr_t         pop_addr;
    cacheline_t    pop_data;
    logic          q_match;
    logic          q_pop;
    logic          enq;
    logic          unused;

    assign rline    = line_align(mem_req_raddr);
    assign widx     = mem_req_waddr[LINE_OFF_BITS +: IW];
    assign pidx     = pop_addr[LINE_OFF_BITS +: IW];
    assign enq      = mem_req_ren && !q_match;
    assign pop_data = (mem_req_wen && widx == pidx)
                    ? mem_req_wcacheline : mem[pidx];
    assign unused   = ^{mem_req_raddr, mem_req_waddr, pop_addr};

    mem_resp_queue #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_addr   (rline),
        .match_addr (rline),
        .match      (q_match),
        .pop        (q_pop),
        .pop_addr   (pop_addr)
    );

    // Storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (mem_req_wen && !rst) begin
            mem[widx] <= mem_req_wcacheline;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rec_en        <= 1'b0;
            mem_rec_addr      <= '0;
            mem_rec_cacheline <= '0;
            rd_accepted       <= '0;
            wr_accepted       <= '0;
        end else begin
            mem_rec_en <= q_pop;
            if (q_pop) begin
                mem_rec_addr      <= pop_addr;
                mem_rec_cacheline <= pop_data;
            end
            rd_accepted <= rd_accepted + 32'(enq);
            wr_accepted <= wr_accepted + 32'(mem_req_wen);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a due-time reference model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic        ren;
    pptr_t       raddr;
    logic        wen;
    pptr_t       waddr;
    cacheline_t  wcl;
    logic        rec_en;
    pptr_t       rec_addr;
    cacheline_t  rec_cl;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    mem_responder #(
        .LATENCY   (LAT),
        .QDEPTH    (8),
        .MEM_LINES (4096)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_req_ren        (ren),
        .mem_req_raddr      (raddr),
        .mem_req_wen        (wen),
        .mem_req_waddr      (waddr),
        .mem_req_wcacheline (wcl),
        .mem_rec_en         (rec_en),
        .mem_rec_addr       (rec_addr),
        .mem_rec_cacheline  (rec_cl),
        .rd_accepted        (rd_cnt),
        .wr_accepted        (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        pptr_t line;
        int    due;
    } pend_t;

    typedef struct {
        pptr_t      addr;
        cacheline_t data;
        bit         known;
    } exp_t;

    pend_t       pend [$];
    exp_t        exp_q [$];
    cacheline_t  mem_m [int];
    int          cyc;
    logic [31:0] rd_exp;
    logic [31:0] wr_exp;
    int          vectors;
    int          miscompares;

    // Model state for one edge.
    pptr_t m_line;
    int    m_widx;
    int    m_pidx;
    bit    m_dup;
    pend_t m_p;
    exp_t  m_e;

    function automatic int idx_of(pptr_t a);
        return int'(a[15:4]);
    endfunction

    // Reference model: a read is due LATENCY edges after acceptance; data is taken at the due edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            rd_exp = 0;
            wr_exp = 0;
        end else begin
            m_line = {raddr[19:4], 4'h0};
            m_widx = idx_of(waddr);
            m_dup  = 1'b0;
            foreach (pend[i]) if (pend[i].line == m_line) m_dup = 1'b1;
            while (pend.size() != 0 && pend[0].due == cyc) begin
                m_p = pend.pop_front();
                m_pidx = idx_of(m_p.line);
                m_e.addr = m_p.line;
                if (wen && m_widx == m_pidx) begin
                    m_e.data = wcl;
                    m_e.known = 1'b1;
                end else if (mem_m.exists(m_pidx)) begin
                    m_e.data = mem_m[m_pidx];
                    m_e.known = 1'b1;
                end else begin
                    m_e.data = '0;
                    m_e.known = 1'b0;
                end
                exp_q.push_back(m_e);
            end
            if (wen) begin
                mem_m[m_widx] = wcl;
                wr_exp++;
            end
            if (ren && !m_dup) begin
                pend.push_back('{line: m_line, due: cyc + LAT});
                rd_exp++;
            end
        end
    end

    exp_t mon_e;

    // Monitor: any cycle with a response or an owed response is one comparison.
    always @(negedge clk) begin
        if (!rst && (rec_en || exp_q.size() != 0)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_rsp: got addr %h, expected no response",
                         rec_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (!rec_en) begin
                    miscompares++;
                    $display("FAIL missing_rsp: en=0, expected addr %h", mon_e.addr);
                end else if (rec_addr !== mon_e.addr
                             || (mon_e.known && rec_cl !== mon_e.data)) begin
                    miscompares++;
                    $display("FAIL rsp: got %h/%h, expected %h/%h",
                             rec_addr, rec_cl, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(pptr_t a, cacheline_t d);
        wen = 1'b1;
        waddr = a;
        wcl = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(pptr_t a);
        ren = 1'b1;
        raddr = a;
        tick();
        ren = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() != 0 || exp_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_timeout", 128'(pend.size() + exp_q.size()), 128'd0);
    endtask

    function automatic cacheline_t rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [31:0] base;

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rd_exp = 0;
        wr_exp = 0;
        rst = 1'b1;
        ren = 1'b1;
        raddr = 20'h00400;
        wen = 1'b0;
        waddr = '0;
        wcl = '0;

        // Reset with a request held high.
        repeat (3) tick();
        chk("rst_en", 128'(rec_en), 128'd0);
        chk("rst_addr", 128'(rec_addr), 128'd0);
        chk("rst_data", rec_cl, 128'd0);
        ren = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_rd_cnt", 128'(rd_cnt), 128'd0);
        chk("rst_wr_cnt", 128'(wr_cnt), 128'd0);

        for (int i = 0; i < 128; i++) wr({4'h0, 12'(i), 4'h0}, rnd_line());
        chk("preload_wr_cnt", 128'(wr_cnt), 128'd128);

        // Single read with offset bits set.
        wr(20'h00120, {16{8'hA5}});
        rd(20'h00123);
        drain();

        // Held request produces one acceptance.
        base = rd_exp;
        ren = 1'b1;
        raddr = 20'h00400;
        repeat (5) tick();
        ren = 1'b0;
        drain();
        chk("held_rd_cnt", 128'(rd_cnt), 128'(base + 32'd1));

        // Write lands while read is in flight.
        rd(20'h00200);
        tick();
        wr(20'h00200, {4{32'hDEADBEEF}});
        drain();

        // Back-to-back distinct reads.
        rd(20'h00100);
        rd(20'h00110);
        rd(20'h00120);
        drain();

        // Reset mid-flight: response lost, storage kept.
        wr(20'h00300, {4{32'h0BADF00D}});
        rd(20'h00310);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rd_cnt", 128'(rd_cnt), 128'd0);
        chk("midrst_wr_cnt", 128'(wr_cnt), 128'd0);
        rd(20'h00300);
        drain();

        // Random mix with aliasing high bits and frequent duplicates.
        for (int i = 0; i < 600; i++) begin
            ren = ($urandom_range(0, 2) != 0);
            raddr = {4'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                     4'($urandom)};
            wen = ($urandom_range(0, 3) == 0);
            waddr = {4'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                     4'($urandom)};
            wcl = rnd_line();
            tick();
        end
        ren = 1'b0;
        wen = 1'b0;
        drain();
        chk("final_rd_cnt", 128'(rd_cnt), 128'(rd_exp));
        chk("final_wr_cnt", 128'(wr_cnt), 128'(wr_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
